// File: rtl/seq_skip_borrow_subtractor.sv
// seq_skip_borrow_subtractor
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one GROUP-bit slice
// per CALC cycle with a registered borrow chain. Valid/ready on both sides.
// Optional macro BORROW_SKIP_EN: groups whose a/b slices are equal (propagate)
// directly following the processed group are completed in the same cycle.
// WIDTH must be a multiple of GROUP.
module seq_skip_borrow_subtractor #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / GROUP;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_borrow;
  logic [PW-1:0]    r_ptr;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_diff_next;
  logic             w_borrow_next;
  logic [PW-1:0]    w_ptr_next;
  logic             w_last;
  logic [GROUP:0]   w_sub;
`ifdef BORROW_SKIP_EN
  logic             w_run;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;

  // Work for one CALC cycle: subtract group r_ptr, then (with skip) fill the
  // run of propagating groups after it, whose digit depends only on the borrow.
  always_comb begin
    w_diff_next   = r_diff;
    w_borrow_next = r_borrow;
    w_ptr_next    = r_ptr;
    w_last        = 1'b0;
    w_sub         = '0;
`ifdef BORROW_SKIP_EN
    w_run         = 1'b0;
`endif
    for (int unsigned g = 0; g < N; g++) begin
      if (PW'(g) == r_ptr) begin
        w_sub = {1'b0, r_a[g*GROUP +: GROUP]} - {1'b0, r_b[g*GROUP +: GROUP]}
              - {{GROUP{1'b0}}, w_borrow_next};
        w_diff_next[g*GROUP +: GROUP] = w_sub[GROUP-1:0];
        w_borrow_next = w_sub[GROUP];
        w_ptr_next    = PW'(g + 1);
        w_last        = (g == N - 1);
`ifdef BORROW_SKIP_EN
        w_run         = 1'b1;
`endif
      end
`ifdef BORROW_SKIP_EN
      else if (PW'(g) > r_ptr) begin
        if (w_run && (r_a[g*GROUP +: GROUP] == r_b[g*GROUP +: GROUP])) begin
          w_diff_next[g*GROUP +: GROUP] = w_borrow_next ? '1 : '0;
          w_ptr_next = PW'(g + 1);
          w_last     = (g == N - 1);
        end else begin
          w_run = 1'b0;
        end
      end
`endif
    end
  end

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_borrow    <= 1'b0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_ptr    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_diff <= w_diff_next;
          if (w_last) begin
            r_bout      <= w_borrow_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_borrow <= w_borrow_next;
            r_ptr    <= w_ptr_next;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_skip_borrow_subtractor.sv
// Scoreboard bench for seq_skip_borrow_subtractor (honours BORROW_SKIP_EN).
module tb_seq_skip_borrow_subtractor;

  localparam int W = 16;
  localparam int G = 4;
  localparam int N = W / G;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;

  seq_skip_borrow_subtractor #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   seen     = 0;
  int   vcyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, latency from counting unequal slices.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, input int acc);
    exp_t e;
    int   calc;
    int   va, vb, vr;
    va = int'(ma);
    vb = int'(mb);
    vr = va - vb - int'(mbin);
    if (vr < 0) vr = vr + (1 << W);
    e.d  = W'(vr);
    e.bo = (va < vb + int'(mbin));
`ifdef BORROW_SKIP_EN
    calc = 1;
    for (int g = 1; g < N; g++)
      if (((va >> (g*G)) & ((1 << G) - 1)) != ((vb >> (g*G)) & ((1 << G) - 1)))
        calc++;
`else
    calc = N;
`endif
    e.lat = calc + 1;
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every cycle the result is presented, pop on handshake.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out actual=diff %0h bout %0b required=no result", diff, bout);
      end else begin
        if (!seen) begin
          seen = 1;
          vcyc = cyc;
        end
        checks++;
        if (diff !== sb[0].d || bout !== sb[0].bo) begin
          failures++;
          $display("FAIL result actual=%0h/%0b required=%0h/%0b", diff, bout, sb[0].d, sb[0].bo);
        end
        if (out_ready === 1'b1) begin
          checks++;
          if (vcyc - sb[0].acc != sb[0].lat) begin
            failures++;
            $display("FAIL latency actual=%0d required=%0d", vcyc - sb[0].acc, sb[0].lat);
          end
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input bit push, input bit keep);
    bit ok;
    ok = 0;
    a = oa;
    b = ob;
    bin = obin;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout actual=no in_ready required=in_ready");
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(model(oa, ob, obin, cyc));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    sb.delete();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL valid_timeout actual=0 required=1");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] ta [7];
    logic [W-1:0] tbv [7];
    logic         tbin [7];
    ta   = '{16'h1234, 16'h5A5A, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000};
    tbv  = '{16'h0001, 16'h5A5B, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001};
    tbin = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tbv[i], tbin[i], 1, 0);
      wait_empty();
    end

    // Back-pressure in DONE with in_valid pulsing
    out_ready = 1'b0;
    issue(16'h1234, 16'h0001, 1'b0, 1, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = ~in_valid;
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the second CALC cycle aborts the transaction
    issue(16'h1234, 16'h0001, 1'b0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high
    issue(16'hBEEF, 16'h1234, 1'b1, 1, 1);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 1, 0);
    wait_empty();

    // Randomized traffic, some slices forced equal, random back-pressure
    for (int i = 0; i < 60; i++) begin
      int stall;
      ra = W'($urandom);
      rb = W'($urandom);
      for (int g = 0; g < N; g++)
        if ($urandom_range(0, 1) == 1) rb[g*G +: G] = ra[g*G +: G];
      stall = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      issue(ra, rb, 1'($urandom), 1, 0);
      if (stall != 0) begin
        wait_valid();
        repeat (stall) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      wait_empty();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
